lab1_tt_checker: RTL
====================

LAB1_TT_CHECKER -- requirements
Module: lab1_tt_checker

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 100, giving clock cycles each input vector is held (legal range 2..1023).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin a sweep.
REQ-005 The block SHALL have port expected, input, 16, the expected truth table; bit i is the expected F for {A,B,C,D}=i.
REQ-006 The block SHALL have port F, input, 1, the response from the combinational DUT under test.
REQ-007 The block SHALL have ports A, B, C, D, output, 1 each, the driven stimulus; A is MSB of the vector index.
REQ-008 The block SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1, a level that is high from sweep completion until the next start or reset.
REQ-010 The block SHALL have port pass, output, 1, high with done when err_count is 0.
REQ-011 The block SHALL have port err_count, output, 5, the number of mismatching vectors (0..16).
REQ-012 The block SHALL have port captured, output, 16, the sampled F per vector index.
REQ-013 The block SHALL have port first_fail, output, 4, the index of the first mismatch; it is valid only when err_count is nonzero.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL cause a transition to DRIVE on the next edge, with vector index 0, hold counter 0, and captured, err_count and first_fail cleared.
REQ-016 start SHALL be ignored in DRIVE.
REQ-017 In DRIVE, {A,B,C,D} SHALL equal the vector index for exactly HOLD_CYCLES consecutive cycles.
REQ-018 F SHALL be sampled on the edge ending the last hold cycle (hold counter = HOLD_CYCLES-1), and the sample SHALL be written to captured[index].
REQ-019 On that sample edge, if F != expected[index], err_count SHALL increment; if this is the first mismatch, first_fail SHALL take the index.
REQ-020 After sampling, the index SHALL increment and the hold counter SHALL clear; after sampling index 15, the FSM SHALL enter DONE without wrapping the index.
REQ-021 With start sampled at edge t, busy SHALL be high for cycles t+1 .. t+16*HOLD_CYCLES, and done SHALL rise at cycle t+1+16*HOLD_CYCLES.
REQ-022 {A,B,C,D} SHALL be 0 in IDLE; in DONE they SHALL hold the last driven vector.
REQ-023 The expected input SHALL be read live at each sample edge and SHALL NOT be latched at start.
REQ-024 busy and done SHALL never be high simultaneously.
REQ-025 err_count SHALL saturate at 16; no overflow is possible.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, with A, B, C, D, busy, done, pass, err_count, captured and first_fail all 0; this applies in any state, including mid-sweep.
REQ-027 When rst and start are both high on the same edge, rst SHALL win.

Configuration
REQ-028 With macro LAB1_CHK_STOP_ON_FAIL_EN defined, the first mismatch sample SHALL move the FSM directly to DONE, leaving err_count=1, pass=0 and unvisited captured bits 0.
REQ-029 Without LAB1_CHK_STOP_ON_FAIL_EN, all 16 vectors SHALL always be swept regardless of mismatches.

Verification (HOLD_CYCLES=4)
REQ-030 Scenario: DUT F=(A&B&C&D)|~(A|B|C|D), expected=16'h8001, pulse start -> busy for 64 cycles, then done=1, pass=1, err_count=0, captured=16'h8001.
REQ-031 Scenario: F tied 0, expected=16'h00F0 -> err_count=4, first_fail=4, captured=16'h0000, pass=0 (macro undefined).
REQ-032 Scenario: same stimulus as REQ-031 with LAB1_CHK_STOP_ON_FAIL_EN defined -> done 20 cycles after start, err_count=1, first_fail=4.
REQ-033 Scenario: rst asserted for one cycle at vector index 7 -> all outputs 0 on the next cycle, and a later start sweeps from index 0.
REQ-034 Scenario: start pulsed again at vector index 3 -> ignored, with the sweep completing on its original schedule.
REQ-035 Scenario: start pulsed in DONE after a failing sweep -> err_count, captured and done clear on the next edge, and the new sweep begins at vector 0.

Source files
------------

// File: rtl/lab1_tt_checker.sv
// Truth-table sweep checker: drives {A,B,C,D} through 0..15, samples F, counts mismatches.
// Optional macro LAB1_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module lab1_tt_checker #(
    parameter int HOLD_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        F,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] captured,
    output logic [3:0]  first_fail
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [9:0] HOLD_LAST = 10'(HOLD_CYCLES - 1);
    localparam logic [4:0] ERR_MAX   = 5'd16;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [9:0]  hold_q, hold_d;
    logic [15:0] cap_q, cap_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ff_q, ff_d;
    logic        mism;
    logic        stop;

    // State register; reset returns everything to an idle, all-zero picture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            hold_q  <= 10'd0;
            cap_q   <= 16'd0;
            err_q   <= 5'd0;
            ff_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    // Next-state: hold each vector, sample F on the last hold cycle, step index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        cap_d   = cap_q;
        err_d   = err_q;
        ff_d    = ff_q;
        mism    = 1'b0;
        stop    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 4'd0;
                    hold_d  = 10'd0;
                    cap_d   = 16'd0;
                    err_d   = 5'd0;
                    ff_d    = 4'd0;
                end
            end
            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    cap_d[idx_q] = F;
                    mism         = (F != expected[idx_q]);
                    if (mism) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 5'd1;
                        end
                        if (err_q == 5'd0) begin
                            ff_d = idx_q;
                        end
                    end
                    hold_d = 10'd0;
`ifdef LAB1_CHK_STOP_ON_FAIL_EN
                    stop = (idx_q == 4'd15) || mism;
`else
                    stop = (idx_q == 4'd15);
`endif
                    if (stop) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 10'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: stimulus is zero in IDLE and holds the last vector in DONE
    always_comb begin
        {A, B, C, D} = (state_q == IDLE) ? 4'd0 : idx_q;
        busy         = (state_q == DRIVE);
        done         = (state_q == DONE);
        pass         = (state_q == DONE) && (err_q == 5'd0);
        err_count    = err_q;
        captured     = cap_q;
        first_fail   = ff_q;
    end

endmodule
